// File: rtl/lut_player.sv
// ---------------------------------------------------------------------------
// lut_player
//
// Playback sequencer for a registered sample ROM. The system clock is divided
// down to the sample rate. Each sample period ends in a capture edge, where
// the ROM word for the current address is latched into sample_out and the
// address moves on. The end of the table either wraps (loop) or finishes
// (one-shot).
//
// Ports:
//   clk_in            system clock; all state changes on the rising edge
//   rst_n_in          asynchronous active-low reset
//   start_in          level; in IDLE, begins playback at index 0
//   stop_in           level; aborts playback and returns to IDLE (wins over start)
//   loop_in           sampled at the end of the table: 1 = wrap, 0 = finish
//   addr_out          registered ROM address
//   data_in           ROM word for the addr_out of the previous clock
//   sample_out        last captured sample, held between strobes
//   sample_valid_out  one-cycle strobe when sample_out updates
//   busy_out          high while in PLAY (this is the FSM state bit)
//   done_out          one-cycle pulse on one-shot completion
//
// Downstream interface: sample_valid_out qualifies sample_out for exactly one
// cycle. There is no ready or backpressure. The consumer must take the sample
// in the strobe cycle, or it can read the held value later.
// ---------------------------------------------------------------------------
module lut_player #(
    parameter int ADDR_BITS = 17,
    parameter int DATA_BITS = 12,
    parameter int TABLE_LEN = 88200,
    parameter int DIV       = 272
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic                 stop_in,
    input  logic                 loop_in,
    output logic [ADDR_BITS-1:0] addr_out,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [DATA_BITS-1:0] sample_out,
    output logic                 sample_valid_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]     DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(TABLE_LEN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;

    logic capture;
    logic at_last;

    // The address has been stable since the previous capture, which is at
    // least DIV-1 >= 1 edges ago. So data_in already holds the word for
    // addr_q when the divider reaches its last count.
    assign capture = (state_q == S_PLAY) && (div_cnt_q == DIV_LAST);
    assign at_last = (addr_q == ADDR_LAST);

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            addr_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            addr_q    <= addr_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_in && !stop_in) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop_in) begin
                    state_d = S_IDLE;
                end else if (capture && at_last && !loop_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        div_cnt_d = div_cnt_q;
        addr_d    = addr_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                addr_d    = '0;
            end
            S_PLAY: begin
                if (stop_in) begin
                    // Stop wins even on a capture edge: no strobe, and the
                    // sample is left as it was.
                    div_cnt_d = '0;
                    addr_d    = '0;
                end else if (capture) begin
                    sample_d  = data_in;
                    valid_d   = 1'b1;
                    div_cnt_d = '0;
                    if (at_last) begin
                        addr_d = '0;
                        done_d = !loop_in;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                div_cnt_d = '0;
                addr_d    = '0;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy_out = (state_q == S_PLAY);
    end

    assign addr_out         = addr_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign done_out         = done_q;

endmodule

// File: tb/tb_lut_player.sv
module tb_lut_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop_en;
    logic [2:0]  addr;
    logic [11:0] rom_q;
    logic [11:0] sample;
    logic        valid, busy, done;

    logic        start2;
    logic [2:0]  addr2;
    logic [11:0] rom2_q;
    logic [11:0] sample2;
    logic        valid2, busy2, done2;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_sample = 12'h000;

    always #5 clk = ~clk;

    lut_player #(.ADDR_BITS(3), .DATA_BITS(12), .TABLE_LEN(4), .DIV(3)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop),
        .loop_in(loop_en), .addr_out(addr), .data_in(rom_q),
        .sample_out(sample), .sample_valid_out(valid), .busy_out(busy),
        .done_out(done)
    );

    lut_player #(.ADDR_BITS(3), .DATA_BITS(12), .TABLE_LEN(5), .DIV(2)) dut2 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start2), .stop_in(1'b0),
        .loop_in(1'b0), .addr_out(addr2), .data_in(rom2_q),
        .sample_out(sample2), .sample_valid_out(valid2), .busy_out(busy2),
        .done_out(done2)
    );

    // ROM models: one-cycle registered read, word[i] = 0x100 + i
    always_ff @(posedge clk) begin
        rom_q  <= 12'h100 + {9'd0, addr};
        rom2_q <= 12'h100 + {9'd0, addr2};
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            step();
            n_checks++;
            if ({valid, done, busy} !== 3'b000 || addr !== 3'd0 || sample !== 12'h000)
                $display("FAIL reset_outputs i=%0d got v=%b d=%b b=%b a=%0d s=%h exp all 0",
                         i, valid, done, busy, addr, sample);
            else n_pass++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || addr !== 3'd0)
            $display("FAIL reset_release got b=%b a=%0d exp 0 0", busy, addr);
        else n_pass++;
    endtask

    task automatic test_one_shot();
        logic       exp_v, exp_d, exp_b;
        logic [2:0] exp_a;
        loop_en = 1'b0;
        start_pulse();
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_v = (c % 3 == 0);
            if (exp_v) exp_sample = 12'(32'h100 + c / 3 - 1);
            exp_d = (c == 12);
            exp_b = (c < 12);
            exp_a = (c == 12) ? 3'd0 : 3'(c / 3);
            n_checks++;
            if (valid !== exp_v) $display("FAIL one_shot_valid c=%0d got %b exp %b", c, valid, exp_v);
            else n_pass++;
            n_checks++;
            if (sample !== exp_sample) $display("FAIL one_shot_sample c=%0d got %h exp %h", c, sample, exp_sample);
            else n_pass++;
            n_checks++;
            if (done !== exp_d || busy !== exp_b)
                $display("FAIL one_shot_done_busy c=%0d got d=%b b=%b exp d=%b b=%b", c, done, busy, exp_d, exp_b);
            else n_pass++;
            n_checks++;
            if (addr !== exp_a) $display("FAIL one_shot_addr c=%0d got %0d exp %0d", c, addr, exp_a);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr !== 3'd0 || sample !== 12'h103)
                $display("FAIL one_shot_after i=%0d got v=%b b=%b d=%b a=%0d s=%h exp 0 0 0 0 103",
                         i, valid, busy, done, addr, sample);
            else n_pass++;
        end
    endtask

    task automatic test_loop();
        logic exp_v;
        loop_en = 1'b1;
        start_pulse();
        for (int c = 1; c <= 30; c++) begin
            step();
            exp_v = (c % 3 == 0);
            if (exp_v) exp_sample = 12'(32'h100 + ((c / 3 - 1) % 4));
            n_checks++;
            if (valid !== exp_v) $display("FAIL loop_valid c=%0d got %b exp %b", c, valid, exp_v);
            else n_pass++;
            n_checks++;
            if (sample !== exp_sample) $display("FAIL loop_sample c=%0d got %h exp %h", c, sample, exp_sample);
            else n_pass++;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1)
                $display("FAIL loop_done_busy c=%0d got d=%b b=%b exp d=0 b=1", c, done, busy);
            else n_pass++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        loop_en = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || addr !== 3'd0 || valid !== 1'b0)
            $display("FAIL loop_stop got b=%b a=%0d v=%b exp 0 0 0", busy, addr, valid);
        else n_pass++;
        step();
    endtask

    task automatic test_stop_capture();
        loop_en = 1'b0;
        start_pulse();
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c % 3 == 0) exp_sample = 12'(32'h100 + c / 3 - 1);
        end
        n_checks++;
        if (sample !== 12'h101 || addr !== 3'd2)
            $display("FAIL stop_pre got s=%h a=%0d exp 101 2", sample, addr);
        else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || done !== 1'b0)
            $display("FAIL stop_no_strobe got v=%b d=%b exp 0 0", valid, done);
        else n_pass++;
        n_checks++;
        if (sample !== 12'h101 || busy !== 1'b0 || addr !== 3'd0)
            $display("FAIL stop_state got s=%h b=%b a=%0d exp 101 0 0", sample, busy, addr);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (valid !== 1'b0 || sample !== 12'h101 || busy !== 1'b0)
                $display("FAIL stop_after i=%0d got v=%b s=%h b=%b exp 0 101 0", i, valid, sample, busy);
            else n_pass++;
        end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || addr !== 3'd0 || valid !== 1'b0)
                $display("FAIL start_stop_idle i=%0d got b=%b a=%0d v=%b exp 0 0 0", i, busy, addr, valid);
            else n_pass++;
        end
        start = 1'b0;
        stop  = 1'b0;
        step();
    endtask

    task automatic test_restart_ignored();
        logic exp_v;
        loop_en = 1'b0;
        start_pulse();
        for (int c = 1; c <= 12; c++) begin
            start = (c == 4 || c == 5);
            step();
            exp_v = (c % 3 == 0);
            if (exp_v) exp_sample = 12'(32'h100 + c / 3 - 1);
            n_checks++;
            if (valid !== exp_v || sample !== exp_sample)
                $display("FAIL restart_seq c=%0d got v=%b s=%h exp v=%b s=%h", c, valid, sample, exp_v, exp_sample);
            else n_pass++;
            n_checks++;
            if (done !== (c == 12)) $display("FAIL restart_done c=%0d got %b exp %b", c, done, (c == 12));
            else n_pass++;
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        logic exp_v;
        loop_en = 1'b1;
        start_pulse();
        step();
        step();
        step();
        n_checks++;
        if (valid !== 1'b1 || sample !== 12'h100)
            $display("FAIL areset_pre got v=%b s=%h exp 1 100", valid, sample);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || sample !== 12'h000 || busy !== 1'b0 || addr !== 3'd0 || done !== 1'b0)
            $display("FAIL areset_clear got v=%b s=%h b=%b a=%0d d=%b exp all 0",
                     valid, sample, busy, addr, done);
        else n_pass++;
        step();
        rst_n = 1'b1;
        loop_en = 1'b0;
        exp_sample = 12'h000;
        step();
        start_pulse();
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_v = (c % 3 == 0);
            if (exp_v) exp_sample = 12'(32'h100 + c / 3 - 1);
            n_checks++;
            if (valid !== exp_v || sample !== exp_sample || done !== (c == 12))
                $display("FAIL areset_rerun c=%0d got v=%b s=%h d=%b exp v=%b s=%h d=%b",
                         c, valid, sample, done, exp_v, exp_sample, (c == 12));
            else n_pass++;
        end
    endtask

    task automatic test_div2();
        logic        exp_v;
        logic [11:0] exp_s2;
        exp_s2 = 12'h000;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = (c % 2 == 0);
            if (exp_v) exp_s2 = 12'(32'h100 + c / 2 - 1);
            n_checks++;
            if (valid2 !== exp_v || sample2 !== exp_s2 || done2 !== (c == 10) || busy2 !== (c < 10))
                $display("FAIL div2_seq c=%0d got v=%b s=%h d=%b b=%b exp v=%b s=%h d=%b b=%b",
                         c, valid2, sample2, done2, busy2, exp_v, exp_s2, (c == 10), (c < 10));
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (valid2 !== 1'b0 || busy2 !== 1'b0 || addr2 !== 3'd0 || sample2 !== 12'h104)
                $display("FAIL div2_after i=%0d got v=%b b=%b a=%0d s=%h exp 0 0 0 104",
                         i, valid2, busy2, addr2, sample2);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        start2  = 1'b0;
        test_reset();
        test_one_shot();
        test_loop();
        test_stop_capture();
        test_start_stop_idle();
        test_restart_ignored();
        test_async_reset();
        test_div2();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lut_player.md
Name: lut_player

Overview:
- Playback sequencer that reads the registered audio sample ROM: 12-bit samples, 88200 entries, one-cycle read latency.
- Generates the ROM address at the audio sample rate by dividing the system clock.
- Captures each returned word and presents it, with a one-cycle valid strobe, to the downstream PWM modulator.
- Supports start, stop, and looped or one-shot playback.

Parameters:
- ADDR_BITS, 17, width of ROM address (must satisfy 2^ADDR_BITS >= TABLE_LEN)
- DATA_BITS, 12, ROM word / sample width
- TABLE_LEN, 88200, number of valid ROM entries; last index is TABLE_LEN-1
- DIV, 272, system clocks per sample (12 MHz / 44.1 kHz, truncated); DIV >= 2 required

Ports:
- clk_in  input  1  system clock; all state on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  level; sampled in IDLE, begins playback at index 0
- stop_in  input  1  level; aborts playback, returns to IDLE
- loop_in  input  1  sampled at end of table; 1 = wrap to index 0, 0 = finish
- addr_out  output  ADDR_BITS  ROM address, registered
- data_in  input  DATA_BITS  ROM data; reflects addr_out from the previous clock
- sample_out  output  DATA_BITS  last captured sample, held between strobes
- sample_valid_out  output  1  one-cycle pulse when sample_out updates
- busy_out  output  1  high while in PLAY
- done_out  output  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset (async assert, sync release): state=IDLE; addr_out=0; div_cnt=0; sample_out=0; sample_valid_out=0; busy_out=0; done_out=0.
- States: IDLE, PLAY.
- IDLE:
  - busy_out=0; addr_out held at 0.
  - start_in=1 and stop_in=0 at an edge -> PLAY; addr_out=0; div_cnt=0.
- PLAY, normal count:
  - div_cnt increments by 1 each edge, range 0..DIV-1, width ceil(log2(DIV)).
  - addr_out is stable at least DIV-1 >= 1 cycles before capture, so data_in is always valid at capture.
- PLAY, capture edge (div_cnt==DIV-1):
  - sample_out <= data_in; sample_valid_out=1 for the following cycle; div_cnt <= 0.
  - If addr_out < TABLE_LEN-1: addr_out <= addr_out+1.
  - If addr_out == TABLE_LEN-1 and loop_in=1: addr_out <= 0; stay in PLAY; no done pulse; wrap is seamless (next sample exactly DIV cycles later).
  - If addr_out == TABLE_LEN-1 and loop_in=0: -> IDLE; addr_out <= 0; done_out=1 for one cycle, coincident with the final sample_valid_out.
- Latency:
  - First sample_valid_out occurs in the cycle after the DIV-th edge following the start edge.
  - Sample period is exactly DIV cycles.
  - One-shot run: TABLE_LEN strobes, then done.
- stop_in=1 in PLAY:
  - -> IDLE at that edge; addr_out <= 0; div_cnt <= 0.
  - No sample_valid_out and no done_out, even if that edge was a capture edge (stop wins).
  - sample_out holds its last value.
- start_in while in PLAY: ignored (no restart).
- start_in and stop_in both high in IDLE: stay IDLE.
- Reset asserted mid-playback: immediate return to the reset values, including an in-progress valid or done pulse.
- addr_out never exceeds TABLE_LEN-1.

Test Plan (bench ROM model: 1-cycle registered read, word[i] = 0x100+i; TABLE_LEN=4, DIV=3 unless stated):
- Reset: hold rst_n_in low, toggle start_in -> all outputs 0, busy_out=0. Release, pulse start_in -> sample_valid_out pulses carry 0x100, 0x101, 0x102, 0x103, spaced exactly 3 cycles; first pulse 3 cycles after the start edge.
- One-shot: loop_in=0 -> done_out pulses together with the 0x103 strobe; busy_out falls; addr_out=0; no further strobes over 20 cycles.
- Loop: loop_in=1 -> sequence 0x100..0x103, 0x100, 0x101... with uniform 3-cycle spacing across the wrap; done_out stays 0.
- Stop on the capture edge of index 2 -> no strobe for 0x102; sample_out stays 0x101; IDLE, addr_out=0.
- start_in and stop_in together in IDLE -> remains IDLE. start_in pulsed mid-playback -> sequence unaffected.
- Async reset asserted between clock edges mid-playback -> outputs cleared before the next edge. Defaults (TABLE_LEN=88200, DIV=272), loop_in=0 -> exactly 88200 strobes, last is word[88199], done_out after 88200*272 cycles.
